// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, instruction field constants, ALU encodings and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Coarse ALU request from the FSM; FUNCT defers to the funct field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  // ALU function codes seen by the datapath
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Everything the FSM decodes from its current state in one bundle.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    aluop_e     aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct
// field into the 3-bit ALU function code. Purely combinational.
module aludec
  import mips_ctrl_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop_i,
  input  logic [FNW-1:0] funct_i,
  output logic [2:0]     alucontrol_o
);

  // Select the ALU function; unknown funct codes fall back to add.
  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_e'(aluop_i))
      ALUOP_ADD:  alucontrol_o = ALU_ADD;
      ALUOP_SUB:  alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FNW'(FN_ADD): alucontrol_o = ALU_ADD;
          FNW'(FN_SUB): alucontrol_o = ALU_SUB;
          FNW'(FN_AND): alucontrol_o = ALU_AND;
          FNW'(FN_OR):  alucontrol_o = ALU_OR;
          FNW'(FN_SLT): alucontrol_o = ALU_SLT;
          default:      alucontrol_o = ALU_ADD;
        endcase
      end
      ALUOP_RSVD: alucontrol_o = ALU_ADD;
      default:    alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, stalls memory states on
// mem_ready, and flags unknown opcodes with a one-cycle illegal_op pulse.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [2:0]     alucontrol,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic           illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  logic is_lw, is_sw, is_rtype, is_beq, is_addi, is_j;

  assign is_lw    = (op == OPW'(OP_LW));
  assign is_sw    = (op == OPW'(OP_SW));
  assign is_rtype = (op == OPW'(OP_RTYPE));
  assign is_beq   = (op == OPW'(OP_BEQ));
  assign is_addi  = (op == OPW'(OP_ADDI));
  assign is_j     = (op == OPW'(OP_J));

  // State register; reset aborts any instruction and restarts at fetch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block purely
    // combinational; a path that left state_d unassigned would infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_EXECUTE;
        else if (is_beq)    state_d = S_BRANCH;
        else if (is_addi)   state_d = S_ADDIEXEC;
        else if (is_j)      state_d = S_JUMP;
        else                state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (is_lw)      state_d = S_MEMRD;
        else if (is_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode of the current state; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b0;
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PC_ALURES;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrca    = 1'b0;
        ctrl.alusrcb    = SRCB_IMM_SH2;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.illegal_op = ~(is_lw | is_sw | is_rtype | is_beq | is_addi | is_j);
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b0;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b0;
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  aludec #(.FNW(FNW)) u_aludec (
    .aluop_i      (ctrl.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  // Write enables and the memory request are suppressed while reset is
  // held so an aborted instruction cannot disturb architectural state.
  assign mem_req    = ctrl.mem_req    & ~reset;
  assign memwrite   = ctrl.memwrite   & ~reset;
  assign irwrite    = ctrl.irwrite    & ~reset;
  assign regwrite   = ctrl.regwrite   & ~reset;
  assign illegal_op = ctrl.illegal_op & ~reset;
  assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));

  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;

endmodule
